// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - round-robin arbiter and APB master sequencer (optional ACCESS timeout: APB_RR_TIMEOUT_EN)
module apb_rr_master #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [4*NUM_REQ-1:0]   req_strb,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [31:0]            PADDR,
    output logic [31:0]            PWDATA,
    output logic [3:0]             PSTRB,
    input  logic [31:0]            PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t         state, state_d;
    logic [IW-1:0]  last, last_d;
    logic [IW-1:0]  gnt, gnt_d;
    logic [IW-1:0]  win;
    logic [IW-1:0]  idx;
    logic           found;

    logic           psel_d, penable_d, pwrite_d, rsp_err_d;
    logic [31:0]    paddr_d, pwdata_d, rsp_rdata_d;
    logic [3:0]     pstrb_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [NUM_REQ-1:0] gnt_onehot;

    logic           win_write;
    logic [31:0]    win_addr, win_wdata;
    logic [3:0]     win_strb;

`ifdef APB_RR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  cnt, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Round-robin search: first requester above the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        win   = last;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Payload mux for the winning requester and one-hot of the held grant.
    always_comb begin
        win_write  = 1'b0;
        win_addr   = '0;
        win_wdata  = '0;
        win_strb   = '0;
        gnt_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                win_write = req_write[i];
                win_addr  = req_addr[32*i +: 32];
                win_wdata = req_wdata[32*i +: 32];
                win_strb  = req_strb[4*i +: 4];
            end
            gnt_onehot[i] = (gnt == IW'(i));
        end
    end

    // Next-state and next values of every registered output.
    always_comb begin
        state_d     = state;
        last_d      = last;
        gnt_d       = gnt;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        pstrb_d     = PSTRB;
        rsp_valid_d = '0;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
`ifdef APB_RR_TIMEOUT_EN
        cnt_d       = cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    last_d    = win;
                    gnt_d     = win;
                    paddr_d   = win_addr;
                    pwrite_d  = win_write;
                    pwdata_d  = win_wdata;
                    pstrb_d   = win_strb;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_RR_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = PSLVERR;
                    if (!PWRITE) begin
                        rsp_rdata_d = PRDATA;
                    end
                    rsp_valid_d = gnt_onehot;
                    state_d     = RESP;
                end
`ifdef APB_RR_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = gnt_onehot;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            last      <= IW'(NUM_REQ - 1);
            gnt       <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_RR_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_d;
            last      <= last_d;
            gnt       <= gnt_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            PSTRB     <= pstrb_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
`ifdef APB_RR_TIMEOUT_EN
            cnt       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - directed vector bench for apb_rr_master
module tb_apb_rr_master;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic [3:0]   req_valid, req_write;
    logic [127:0] req_addr, req_wdata;
    logic [15:0]  req_strb;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         PSEL, PENABLE, PWRITE;
    logic [31:0]  PADDR, PWDATA, PRDATA;
    logic [3:0]   PSTRB;
    logic         PREADY, PSLVERR;

    apb_rr_master #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave model: memory with programmable wait states; garbage PSLVERR/PRDATA while not ready.
    logic [31:0] mem [0:15];
    int slave_waits = 0;
    logic slave_err = 1'b0;
    int wcnt = 0;

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (wcnt < slave_waits) begin
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                PRDATA  = 32'hBAD0BAD0;
                wcnt++;
            end else begin
                PREADY  = 1'b1;
                PSLVERR = slave_err;
                PRDATA  = mem[PADDR[5:2]];
                if (PWRITE) begin
                    for (int b = 0; b < 4; b++)
                        if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] = PWDATA[8*b +: 8];
                end
            end
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = '0;
            wcnt    = 0;
        end
    end

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        serr;
        int          exp_pen;
        logic [3:0]  exp_rsp;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic run_vec(input vec_t v);
        int n_psel, n_pen, cyc;
        bit got, first, pw_bad;
        logic [3:0]  cap_rsp;
        logic        cap_err;
        logic [31:0] cap_rdata, cap_addr;
        logic        cap_wr;
        logic [3:0]  cap_strb;
        n_psel = 0; n_pen = 0; cyc = 0; got = 0; first = 1; pw_bad = 0;
        cap_rsp = '0; cap_err = 0; cap_rdata = '0; cap_addr = '0; cap_wr = 0; cap_strb = '0;
        slave_waits = v.waits;
        slave_err   = v.serr;
        req_valid[v.id]          = 1'b1;
        req_write[v.id]          = v.wr;
        req_addr[32*v.id +: 32]  = v.addr;
        req_wdata[32*v.id +: 32] = v.wdata;
        req_strb[4*v.id +: 4]    = v.strb;
        while (!got && cyc < 2000) begin
            @(negedge PCLK);
            cyc++;
            if (PSEL) begin
                n_psel++;
                if (PWDATA !== v.wdata) pw_bad = 1;
                if (first) begin
                    first = 0; cap_addr = PADDR; cap_wr = PWRITE; cap_strb = PSTRB;
                end
            end
            if (PENABLE) n_pen++;
            if (rsp_valid != 0) begin
                got = 1; cap_rsp = rsp_valid; cap_err = rsp_err; cap_rdata = rsp_rdata;
            end
        end
        req_valid[v.id] = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("rsp_valid", 32'(cap_rsp), 32'(v.exp_rsp));
        chk("rsp_err", 32'(cap_err), 32'(v.exp_err));
        chk("rsp_rdata", cap_rdata, v.exp_rdata);
        chk("paddr", cap_addr, v.addr);
        chk("pwrite", 32'(cap_wr), 32'(v.wr));
        chk("pstrb", 32'(cap_strb), 32'(v.strb));
        chk("pwdata_stable", 32'(pw_bad), 32'd0);
        chk("psel_cycles", 32'(n_psel), 32'(v.exp_pen + 1));
        chk("penable_cycles", 32'(n_pen), 32'(v.exp_pen));
        @(negedge PCLK);
        chk("rsp_pulse_clear", 32'(rsp_valid), 32'd0);
        chk("idle_psel", 32'(PSEL), 32'd0);
        chk("rdata_hold", rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        int cyc, nrsp, nset, gap;
        bit seen, got;
        PRESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        PREADY = 0; PSLVERR = 0; PRDATA = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        vq.push_back('{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1'b0, 3, 4'b0001, 1'b0, 32'h0});
        vq.push_back('{2, 1'b0, 32'h10, 32'h11111111, 4'hF, 0, 1'b0, 1, 4'b0100, 1'b0, 32'hDEADBEEF});
        vq.push_back('{1, 1'b1, 32'h14, 32'h12345678, 4'h3, 1, 1'b0, 2, 4'b0010, 1'b0, 32'hDEADBEEF});
        vq.push_back('{1, 1'b0, 32'h14, 32'h0,        4'h0, 0, 1'b1, 1, 4'b0010, 1'b1, 32'h00005678});
        vq.push_back('{3, 1'b0, 32'h14, 32'h22222222, 4'h0, 3, 1'b0, 4, 4'b1000, 1'b0, 32'h00005678});
        vq.push_back('{0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'h8, 0, 1'b0, 1, 4'b0001, 1'b0, 32'h00005678});
        vq.push_back('{2, 1'b0, 32'h10, 32'h33333333, 4'h0, 0, 1'b0, 1, 4'b0100, 1'b0, 32'hA5ADBEEF});
`ifdef APB_RR_TIMEOUT_EN
        vq.push_back('{1, 1'b0, 32'h14, 32'h0,        4'h0, 15,   1'b0, 16, 4'b0010, 1'b0, 32'h00005678});
        vq.push_back('{0, 1'b0, 32'h10, 32'h0,        4'h0, 1000, 1'b0, 16, 4'b0001, 1'b1, 32'h0});
`else
        vq.push_back('{3, 1'b0, 32'h10, 32'h0,        4'h0, 20,   1'b0, 21, 4'b1000, 1'b0, 32'hA5ADBEEF});
`endif

        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pstrb", 32'(PSTRB), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("idle_no_req", 32'(PSEL), 32'd0);

        foreach (vq[i]) run_vec(vq[i]);

        // Fairness with all requesters held high, starting from a fresh reset.
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        slave_waits = 0; slave_err = 0;
        for (int i = 0; i < 4; i++) begin
            req_addr[32*i +: 32] = 32'h100 + 32'(4*i);
            req_write[i] = 1'b0;
        end
        req_valid = 4'hF;
        nrsp = 0; nset = 0; gap = 0; seen = 0; cyc = 0;
        while (nrsp < 8 && cyc < 200) begin
            @(negedge PCLK);
            cyc++;
            if (PSEL && !PENABLE) begin
                chk("fair_paddr", PADDR, 32'h100 + 32'(4*(nset % 4)));
                if (seen) chk("fair_gap", 32'(gap), 32'd2);
                nset++;
            end
            if (PSEL) begin seen = 1; gap = 0; end else gap++;
            if (rsp_valid != 0) begin
                chk("fair_grant", 32'(rsp_valid), 32'(4'b0001 << (nrsp % 4)));
                nrsp++;
                if (nrsp == 8) req_valid = '0;
            end
        end
        chk("fair_count", 32'(nrsp), 32'd8);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("fair_stop", 32'(PSEL), 32'd0);

        // Reset while in ACCESS: no response, then req3 retried and granted first.
        slave_waits = 10;
        req_valid[3] = 1'b1; req_write[3] = 1'b1;
        req_addr[127:96] = 32'h30; req_wdata[127:96] = 32'h0BADCAFE; req_strb[15:12] = 4'hF;
        cyc = 0;
        while (!PENABLE && cyc < 20) begin @(negedge PCLK); cyc++; end
        chk("mid_reach_access", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_paddr", PADDR, 32'd0);
        PRESET = 1'b0;
        slave_waits = 0;
        got = 0; cyc = 0; seen = 0;
        while (!got && cyc < 50) begin
            @(negedge PCLK);
            cyc++;
            if (PSEL && !seen) begin
                seen = 1;
                chk("retry_paddr", PADDR, 32'h30);
            end
            if (rsp_valid != 0) begin
                got = 1;
                chk("retry_rsp_valid", 32'(rsp_valid), 32'b1000);
                chk("retry_rsp_err", 32'(rsp_err), 32'd0);
            end
        end
        chk("retry_seen", 32'(got), 32'd1);
        req_valid = '0;
        @(negedge PCLK);
        chk("retry_mem", mem[12], 32'h0BADCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
